// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit FIFO between NUM_REQ requesters: round-robin grant, then the
// owner keeps the FIFO until it pushes EOL_CHAR or idles for LOCK_TIMEOUT cycles.
// Optional build macro UART_ARB_TAG_EN prefixes every locked message with an ASCII owner digit.
//
// state    | meaning
// S_IDLE   | no owner; round-robin search from rr_ptr
// S_TAG    | (UART_ARB_TAG_EN only) pushing the '0'+owner tag byte
// S_LOCKED | owner streams bytes until EOL or idle timeout
module uart_tx_arbiter #(
   parameter int                    NUM_REQ      = 4,
   parameter int                    DATA_WIDTH   = 8,
   parameter logic [DATA_WIDTH-1:0] EOL_CHAR     = 'h0A,
   parameter int                    LOCK_TIMEOUT = 255,
   localparam int                   GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic [DATA_WIDTH-1:0]         fifo_byte,
   output logic                          fifo_push,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
`ifdef UART_ARB_TAG_EN
      S_TAG    = 2'd1,
`endif
      S_LOCKED = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [GW-1:0]           owner_q, owner_d;
   logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [7:0]              idle_cnt_q, idle_cnt_d;

   logic [GW-1:0]           winner;
   logic                    found;
   int                      idx;
   logic [GW-1:0]           owner_next;
   logic [DATA_WIDTH-1:0]   owner_byte;
   logic                    owner_valid;

   // First set req_valid bit at or after rr_ptr, wrapping.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
   end

   assign owner_next  = (int'(owner_q) == NUM_REQ - 1) ? '0 : GW'(owner_q + 1'b1);
   assign owner_byte  = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
   assign owner_valid = req_valid[owner_q];

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      idle_cnt_d = idle_cnt_q;
      fifo_push  = 1'b0;
      fifo_byte  = '0;
      req_ready  = '0;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               owner_d    = winner;
               idle_cnt_d = '0;
`ifdef UART_ARB_TAG_EN
               state_d    = S_TAG;
`else
               state_d    = S_LOCKED;
`endif
            end
         end
`ifdef UART_ARB_TAG_EN
         S_TAG: begin
            if (!fifo_full) begin
               fifo_push = 1'b1;
               fifo_byte = DATA_WIDTH'(8'h30) + DATA_WIDTH'(owner_q);
               state_d   = S_LOCKED;
            end
         end
`endif
         S_LOCKED: begin
            if (owner_valid) begin
               if (!fifo_full) begin
                  fifo_push          = 1'b1;
                  fifo_byte          = owner_byte;
                  req_ready[owner_q] = 1'b1;
                  idle_cnt_d         = '0;
                  if (owner_byte == EOL_CHAR) begin
                     state_d  = S_IDLE;
                     rr_ptr_d = owner_next;
                  end
               end
            end else begin
               // Owner went quiet: count toward a forced release; nothing is pending, so no byte is lost.
               idle_cnt_d = (idle_cnt_q == 8'hFF) ? idle_cnt_q : idle_cnt_q + 8'd1;
               if (idle_cnt_q == 8'(LOCK_TIMEOUT - 1)) begin
                  state_d  = S_IDLE;
                  rr_ptr_d = owner_next;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign grant_id = owner_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO between NUM_REQ requesters, typically one per core.
- Round-robin grant, then locks to the owner until a newline byte or an idle timeout, so lines from different cores never interleave.
- Sits between the per-core UART APB slaves and the uart_fifo transmit port (tx_byte / transmit / tx_fifo_full).

Parameters:
- NUM_REQ, 4, number of requesters (2..10).
- DATA_WIDTH, 8, byte width.
- EOL_CHAR, 8'h0A, byte that ends a lock.
- LOCK_TIMEOUT, 255, idle owner cycles before forced release (>=1).
- GW, $clog2(NUM_REQ) (min 1), grant index width (derived localparam).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  requester i has a byte.
- req_data  input  NUM_REQ*DATA_WIDTH  byte of requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  byte of requester i accepted this cycle.
- fifo_full  input  1  from uart_fifo tx_fifo_full.
- fifo_byte  output  DATA_WIDTH  to uart_fifo tx_byte.
- fifo_push  output  1  to uart_fifo transmit.
- grant_id  output  GW  current or last owner.
- busy  output  1  high when state != IDLE.

Behaviour:
- Registered state: state {IDLE, TAG, LOCKED}, owner, rr_ptr, idle_cnt (8 bits, saturating).
- Reset (reset=0, asynchronous) drives: state=IDLE, owner=0, rr_ptr=0, idle_cnt=0.
  - Therefore fifo_push=0, req_ready=0, busy=0, grant_id=0, fifo_byte=0.
  - Reset mid-message abandons the lock. A byte not yet pushed is not pushed.
- Push rule: fifo_push and req_ready are combinational from state, owner, req_valid and fifo_full.
  - fifo_push=1 only when fifo_full=0.
  - At most one req_ready bit high per cycle, never while fifo_full=1.
  - fifo_byte is 0 whenever fifo_push=0.
- IDLE:
  - Search req_valid starting at index rr_ptr, ascending, wrapping modulo NUM_REQ. The first set bit wins.
  - Next cycle: owner=winner, idle_cnt=0, state=LOCKED (or TAG, see optional feature).
  - No byte is transferred in IDLE. First-byte latency from request is 1 cycle plus FIFO stall.
- LOCKED, transfer cycle (req_valid[owner]=1 and fifo_full=0):
  - fifo_push=1, fifo_byte=req_data[owner], req_ready[owner]=1, idle_cnt<=0.
  - If the byte equals EOL_CHAR: state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ.
- LOCKED, stall (req_valid[owner]=1 and fifo_full=1): no push; idle_cnt holds.
- LOCKED, idle (req_valid[owner]=0): idle_cnt increments.
  - When idle_cnt==LOCK_TIMEOUT-1 on an idle cycle: state<=IDLE, rr_ptr<=(owner+1) mod NUM_REQ.
  - This is a forced release with no byte lost.
- Non-owners are ignored while locked. Their req_ready stays 0 and their data is held by them.
- grant_id = owner in every state.
- Fairness: the requester that just released has lowest priority at the next arbitration.
- Back-to-back: an EOL push in cycle N gives IDLE in N+1 and the new owner LOCKED in N+2.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- With the macro defined:
  - IDLE transitions to TAG instead of LOCKED.
  - In TAG, when fifo_full=0: fifo_push=1, fifo_byte=8'h30+owner (ASCII core digit), req_ready all 0; next state LOCKED.
  - In TAG, when fifo_full=1: hold TAG.
  - TAG does not count toward the timeout.
- Without the macro: the TAG state is not built; IDLE goes directly to LOCKED. Output is bit-identical to the untagged stream.

Test Plan:
- Reset: hold reset=0 with req_valid=4'b1111 -> fifo_push=0, req_ready=0, busy=0, grant_id=0. Release reset -> grant_id=0 and busy=1 one cycle later.
- Interleave: req0 sends "AB\n" while req1 holds "X" valid -> FIFO receives 41,42,0A,58 in order. req_ready[1] stays 0 until after 0A.
- Round-robin: all four valid, each sending a single "\n" -> grants in order 0,1,2,3,0. Each EOL push is two cycles after the previous one.
- Full stall: owner valid with fifo_full=1 for 300 cycles -> no push, no release. Dropping fifo_full pushes the byte in the same cycle.
- Timeout (LOCK_TIMEOUT=255): owner pushes 'A' then deasserts valid -> release after 255 idle cycles. The waiting req2 is granted next, and 'A' is not duplicated.
- UART_ARB_TAG_EN: req2 sends "Z\n" -> FIFO receives 32,5A,0A. With fifo_full=1 during TAG, the tag is held and no data byte is accepted.
